// File: rtl/pu_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pu_ctrl_pkg - FSM state encoding and default constants shared by PU controllers
// Rev 1.0
// ----------------------------------------------------------------------------
package pu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } pu_state_e;

  // One synchronous memory read plus two PU register stages.
  localparam int unsigned c_LAT_DEFAULT = 3;

  localparam int unsigned c_ACC_W_DEFAULT = 16;
  localparam logic [c_ACC_W_DEFAULT-1:0] c_ACC_SAT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/pu_valid_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pu_valid_delay - DEPTH-stage 1-bit valid shift register with an empty flag
// Rev 1.0
// ----------------------------------------------------------------------------
module pu_valid_delay
  import pu_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = c_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic valid_o,
  output logic empty_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | DEPTH'(valid_i);
    end
  end

  assign valid_o = pipe_q[DEPTH-1];
  assign empty_o = ~|pipe_q;

endmodule
`default_nettype wire

// File: rtl/pu_dot_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pu_dot_controller - sequences one PU through a multi-group dot product with
// saturating accumulation and a valid/ready result handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module pu_dot_controller
  import pu_ctrl_pkg::*;
#(
  parameter int unsigned PU_OUT_W = 12,
  parameter int unsigned ACC_W    = c_ACC_W_DEFAULT,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned LAT      = c_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_groups,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [PU_OUT_W-1:0] pu_out,
  output logic                busy,
  output logic [ACC_W-1:0]    result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                overflow
);

  localparam logic [ACC_W-1:0] c_ACC_MAX = '1;

  pu_state_e          state_q;
  logic [CNT_W-1:0]   groups_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   accum_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_rd_en_q;
  logic               busy_q;
  logic               result_valid_q;
  logic               overflow_q;
  logic [ACC_W-1:0]   acc_q;

  logic               pu_valid;
  logic               dl_empty;
  logic [ACC_W:0]     sum_d;
  logic [ACC_W-1:0]   acc_d;
  logic               overflow_d;
  logic               last_acc;
  logic [ADDR_W-1:0]  addr_d;

  pu_valid_delay #(
    .DEPTH (LAT)
  ) u_valid_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (mem_rd_en_q),
    .valid_o (pu_valid),
    .empty_o (dl_empty)
  );

  always_comb begin
    sum_d      = {1'b0, acc_q} + (ACC_W+1)'(pu_out);
    acc_d      = sum_d[ACC_W] ? c_ACC_MAX : sum_d[ACC_W-1:0];
    overflow_d = overflow_q | sum_d[ACC_W];
    // The final product arrives while DRAIN waits; leaving on it saves a cycle.
    last_acc   = pu_valid && (accum_q == (groups_q - CNT_W'(1)));
    addr_d     = base_q + ADDR_W'(issued_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      groups_q       <= '0;
      issued_q       <= '0;
      accum_q        <= '0;
      base_q         <= '0;
      mem_addr_q     <= '0;
      mem_rd_en_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      acc_q          <= '0;
    end else begin
      if (pu_valid) begin
        acc_q      <= acc_d;
        overflow_q <= overflow_d;
        accum_q    <= accum_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            groups_q   <= num_groups;
            base_q     <= base_addr;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            accum_q    <= '0;
            busy_q     <= 1'b1;
            if (num_groups != '0) begin
              state_q     <= ST_ISSUE;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= base_addr;
              issued_q    <= CNT_W'(1);
            end else begin
              state_q        <= ST_HOLD;
              result_valid_q <= 1'b1;
              issued_q       <= '0;
            end
          end
        end

        ST_ISSUE: begin
          if (issued_q == groups_q) begin
            mem_rd_en_q <= 1'b0;
            state_q     <= ST_DRAIN;
          end else begin
            mem_addr_q <= addr_d;
            issued_q   <= issued_q + CNT_W'(1);
          end
        end

        ST_DRAIN: begin
          if (last_acc || dl_empty) begin
            state_q        <= ST_HOLD;
            result_valid_q <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (result_ready) begin
            state_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en    = mem_rd_en_q;
  assign mem_addr     = mem_addr_q;
  assign busy         = busy_q;
  assign result       = acc_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_dot_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pu_dot_controller - directed and randomized checks of pu_dot_controller
// at ACC_W=16 and ACC_W=13 against a plain-arithmetic dot-product model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pu_dot_controller;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_groups;
  logic [5:0]  base_addr;
  logic [11:0] pu_out;
  logic        result_ready;

  logic        a_rd, b_rd;
  logic [5:0]  a_addr, b_addr;
  logic        a_busy, b_busy;
  logic [15:0] a_res;
  logic [12:0] b_res;
  logic        a_val, b_val;
  logic        a_ovf, b_ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int vals[16];

  always #5 clk = ~clk;

  pu_dot_controller u_dut16 (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups), .base_addr(base_addr),
    .mem_rd_en(a_rd), .mem_addr(a_addr), .pu_out(pu_out), .busy(a_busy), .result(a_res),
    .result_valid(a_val), .result_ready(result_ready), .overflow(a_ovf)
  );

  pu_dot_controller #(.ACC_W(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups), .base_addr(base_addr),
    .mem_rd_en(b_rd), .mem_addr(b_addr), .pu_out(pu_out), .busy(b_busy), .result(b_res),
    .result_valid(b_val), .result_ready(result_ready), .overflow(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " rd_en"}, a_rd, 0);   chk({tag, " rd_en13"}, b_rd, 0);
    chk({tag, " addr"}, a_addr, 0);  chk({tag, " addr13"}, b_addr, 0);
    chk({tag, " busy"}, a_busy, 0);  chk({tag, " busy13"}, b_busy, 0);
    chk({tag, " result"}, a_res, 0); chk({tag, " result13"}, b_res, 0);
    chk({tag, " valid"}, a_val, 0);  chk({tag, " valid13"}, b_val, 0);
    chk({tag, " ovf"}, a_ovf, 0);    chk({tag, " ovf13"}, b_ovf, 0);
  endtask

  // Dot product result: true sum of the first n group values, clipped at 2^w-1.
  task automatic run_op(input int n, input int base, input int hold, input bit start_in_hold);
    int s;
    int vc;
    int max16;
    int max13;
    int e16;
    int e13;
    s = 0;
    for (int i = 0; i < n; i++) s += vals[i];
    max16 = (1 << 16) - 1;
    max13 = (1 << 13) - 1;
    e16 = (s > max16) ? max16 : s;
    e13 = (s > max13) ? max13 : s;
    vc = (n == 0) ? 1 : n + LAT + 1;

    start = 1'b1; num_groups = 4'(n); base_addr = 6'(base);
    step();
    start = 1'b0; num_groups = 4'($urandom); base_addr = 6'($urandom);
    for (int c = 1; c <= vc; c++) begin
      if (c > 1) step();
      if (c - LAT >= 1 && c - LAT <= n) pu_out = 12'(vals[c - LAT - 1]);
      else                              pu_out = 12'($urandom_range(1, 4095));
      chk("mem_rd_en", a_rd, 32'(c <= n));
      chk("mem_rd_en13", b_rd, 32'(c <= n));
      if (c <= n) begin
        chk("mem_addr", a_addr, 32'((base + c - 1) % 64));
        chk("mem_addr13", b_addr, 32'((base + c - 1) % 64));
      end
      chk("busy", a_busy, 1);
      chk("busy13", b_busy, 1);
      chk("result_valid", a_val, 32'(c == vc));
      chk("result_valid13", b_val, 32'(c == vc));
    end
    chk("result", a_res, 32'(e16));
    chk("result13", b_res, 32'(e13));
    chk("overflow", a_ovf, 32'(s > max16));
    chk("overflow13", b_ovf, 32'(s > max13));

    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      if (start_in_hold && h == 0) begin
        start = 1'b1; num_groups = 4'd5;
      end
      step();
      start = 1'b0;
      pu_out = 12'($urandom_range(1, 4095));
      chk("hold valid", a_val, 1);
      chk("hold valid13", b_val, 1);
      chk("hold result", a_res, 32'(e16));
      chk("hold result13", b_res, 32'(e13));
      chk("hold ovf13", b_ovf, 32'(s > max13));
      chk("hold rd_en", a_rd, 0);
    end

    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("post-handshake valid", a_val, 0);
    chk("post-handshake valid13", b_val, 0);
    chk("post-handshake busy", a_busy, 0);
    chk("post-handshake result held", a_res, 32'(e16));
    chk("post-handshake result13 held", b_res, 32'(e13));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_groups = '0; base_addr = '0;
    pu_out = '0; result_ready = 1'b0;
    step();
    step();
    chk_idle_zero("reset");
    #2 rst = 1'b0;
    step();

    // Basic three-group product
    vals[0] = 10; vals[1] = 20; vals[2] = 30;
    run_op(3, 5, 0, 1'b0);

    // Empty product
    run_op(0, 17, 0, 1'b0);

    // Long hold with an ignored start, then back-to-back start
    vals[0] = 1000; vals[1] = 2345;
    run_op(2, 40, 10, 1'b1);

    // Address wrap
    vals[0] = 1; vals[1] = 2; vals[2] = 3;
    run_op(3, 62, 1, 1'b0);

    // Saturation in the narrow accumulator only
    vals[0] = 4095; vals[1] = 4095; vals[2] = 4095;
    run_op(3, 0, 0, 1'b0);

    // Longest product
    for (int i = 0; i < 16; i++) vals[i] = 4095;
    run_op(15, 50, 2, 1'b0);

    // Randomized products
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) vals[i] = int'($urandom_range(0, 4095));
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Asynchronous reset mid-issue
    vals[0] = 500; vals[1] = 600;
    start = 1'b1; num_groups = 4'd5; base_addr = 6'd10;
    step();
    start = 1'b0;
    step();
    pu_out = 12'd100;
    #2 rst = 1'b1;
    #1;
    chk_idle_zero("async reset");
    step();
    pu_out = 12'd999;
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      pu_out = 12'($urandom_range(1, 4095));
    end
    chk("after reset result", a_res, 0);
    chk("after reset result13", b_res, 0);
    chk("after reset busy", a_busy, 0);
    chk("after reset valid", a_val, 0);

    vals[0] = 7;
    run_op(1, 33, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
